// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle HI/LO multiply/accumulate and restoring-divide sequencer
module muldiv_ctrl #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             hold,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  output logic             stall,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, nxt;
  logic [2:0] op_r;
  logic [WIDTH-1:0] ra, rb, rh, rl, abs_a, abs_b, qn, rn;
  logic [CW-1:0] cnt;
  logic qneg, rneg, is_div, sgn_in, sx, go, last_mul, last_div;
  logic [2*WIDTH-1:0] prod, acc;
  logic [WIDTH:0] rs, diff;
  assign is_div   = ~op[2] & op[1];
  assign sgn_in   = ~op[0];
  assign go       = state == IDLE & start & ~flush;
  assign abs_a    = (sgn_in & src_a[WIDTH-1]) ? -src_a : src_a;
  assign abs_b    = (sgn_in & src_b[WIDTH-1]) ? -src_b : src_b;
  assign last_mul = cnt == CW'(MUL_LAT - 1);
  assign last_div = cnt == CW'(WIDTH - 1);
  assign sx       = ~op_r[0];
  assign prod     = {{WIDTH{sx & ra[WIDTH-1]}}, ra} * {{WIDTH{sx & rb[WIDTH-1]}}, rb};
  assign acc      = ~op_r[2] ? prod : op_r[1] ? {rh, rl} - prod : {rh, rl} + prod;
  // restoring step: rh holds the partial remainder, ra shifts dividend out and quotient in
  assign rs       = {rh, ra[WIDTH-1]};
  assign diff     = rs - {1'b0, rb};
  assign qn       = {ra[WIDTH-2:0], ~diff[WIDTH]};
  assign rn       = diff[WIDTH] ? rs[WIDTH-1:0] : diff[WIDTH-1:0];
  assign result_valid = state == DONE;
  always_comb begin
    nxt   = state;
    stall = ~flush & ((state == IDLE & start) | state == MUL | state == DIV);
    busy  = state != IDLE;
    if (flush) nxt = IDLE;
    else
      unique case (state)
        IDLE: if (start) nxt = is_div ? (~|src_b ? DONE : DIV) : MUL;
        MUL:  if (last_mul) nxt = DONE;
        DIV:  if (last_div) nxt = DONE;
        DONE: if (!hold) nxt = IDLE;
        default: nxt = IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r   <= '0;
      ra     <= '0;
      rb     <= '0;
      rh     <= '0;
      rl     <= '0;
      qneg   <= 1'b0;
      rneg   <= 1'b0;
      cnt    <= '0;
      hi_out <= '0;
      lo_out <= '0;
    end else if (go) begin
      op_r <= op;
      cnt  <= '0;
      ra   <= is_div ? abs_a : src_a;
      rb   <= is_div ? abs_b : src_b;
      rh   <= is_div ? '0 : hi_in;
      rl   <= lo_in;
      qneg <= sgn_in & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
      rneg <= sgn_in & src_a[WIDTH-1];
      if (is_div & ~|src_b) begin
        hi_out <= src_a;
        lo_out <= '1;
      end
    end else if (~flush & (state == MUL | state == DIV)) begin
      cnt <= cnt + 1'b1;
      if (state == DIV) begin
        ra <= qn;
        rh <= rn;
      end
      if (state == MUL & last_mul) {hi_out, lo_out} <= acc;
      if (state == DIV & last_div) begin
        hi_out <= rneg ? -rn : rn;
        lo_out <= qneg ? -qn : qn;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: vector table plus scoreboard checks for muldiv_ctrl
module tb_muldiv_ctrl;
  logic clk = 0, rst, flush, hold, start;
  logic [2:0] op;
  logic [31:0] src_a, src_b, hi_in, lo_in, hi_out, lo_out;
  logic stall, busy, result_valid;
  int nchk = 0, nfail = 0;
  logic [63:0] sb[$];
  logic [63:0] last_exp = '0;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic [63:0] exp;
    int          lat;
  } vec_t;
  vec_t vt[12];
  always #5 clk = ~clk;
  muldiv_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .hi_in(hi_in), .lo_in(lo_in),
    .stall(stall), .busy(busy), .result_valid(result_valid),
    .hi_out(hi_out), .lo_out(lo_out)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, b, h, l);
    longint sa = $signed(a), sbv = $signed(b);
    longint unsigned ua = a, ub = b;
    logic [63:0] p, q, r;
    if (o == 3'd2 || o == 3'd3) begin
      if (b == 0) return {a, 32'hFFFFFFFF};
      if (o == 3'd3) return {a % b, a / b};
      q = sa / sbv;
      r = sa % sbv;
      return {r[31:0], q[31:0]};
    end
    p = o[0] ? ua * ub : sa * sbv;
    return (o < 3'd4) ? p : (o < 3'd6) ? {h, l} + p : {h, l} - p;
  endfunction
  task automatic run_op(input vec_t v);
    int n = 0;
    logic [63:0] e;
    op = v.op; src_a = v.a; src_b = v.b; hi_in = v.hi; lo_in = v.lo; start = 1;
    sb.push_back(v.exp);
    #1;
    while (!result_valid && n < 40) begin
      chk("stall_wait", stall, 1);
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, v.lat);
    e = sb.pop_front();
    last_exp = e;
    chk("result", {hi_out, lo_out}, e);
    chk("stall_done", stall, 0);
    @(posedge clk); #1;
    start = 0;
    #1;
    chk("idle_after", {busy, result_valid}, 0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t v;
    logic [63:0] e;
    vt[0]  = '{3'd0, 32'hFFFFFFFD, 32'd5, 32'd0, 32'd0, 64'hFFFFFFFF_FFFFFFF1, 2};
    vt[1]  = '{3'd3, 32'd100, 32'd7, 32'd0, 32'd0, 64'h00000002_0000000E, 33};
    vt[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 64'hFFFFFFFF_FFFFFFFD, 33};
    vt[3]  = '{3'd4, 32'd3, 32'd4, 32'd0, 32'd10, 64'h00000000_00000016, 2};
    vt[4]  = '{3'd7, 32'd2, 32'd3, 32'd0, 32'd5, 64'hFFFFFFFF_FFFFFFFF, 2};
    vt[5]  = '{3'd2, 32'h1234, 32'd0, 32'd0, 32'd0, 64'h00001234_FFFFFFFF, 1};
    vt[6]  = '{3'd1, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 64'h00000001_FFFFFFFE, 2};
    vt[7]  = '{3'd2, 32'd7, 32'hFFFFFFFE, 32'd0, 32'd0, 64'h00000001_FFFFFFFD, 33};
    vt[8]  = '{3'd6, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 64'h00000000_00000001, 2};
    vt[9]  = '{3'd3, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 64'hFFFFFFFF_FFFFFFFF, 1};
    vt[10] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 64'h00000000_80000000, 33};
    vt[11] = '{3'd5, 32'd1, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 2};
    rst = 1; flush = 0; hold = 0; start = 0; op = 0;
    src_a = 0; src_b = 0; hi_in = 0; lo_in = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {stall, busy, result_valid, hi_out, lo_out}, 0);
    rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) run_op(vt[i]);
    for (int i = 0; i < 8; i++) begin
      v.op = 3'($urandom_range(0, 7));
      v.a = $urandom; v.hi = $urandom; v.lo = $urandom;
      v.b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      v.exp = model(v.op, v.a, v.b, v.hi, v.lo);
      v.lat = (v.op == 3'd2 || v.op == 3'd3) ? (v.b == 0 ? 1 : 33) : 2;
      run_op(v);
    end
    // flush partway through a divide
    op = 3'd3; src_a = 100; src_b = 7; start = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("fl_stall", {stall, result_valid}, 2'b10);
      @(posedge clk);
    end
    #1 flush = 1;
    #1 chk("fl_cut", stall, 0);
    @(posedge clk); #1;
    flush = 0; start = 0;
    #1;
    chk("fl_idle", {busy, result_valid}, 0);
    chk("fl_keep", {hi_out, lo_out}, last_exp);
    @(posedge clk); #1;
    run_op('{3'd0, 32'hFFFFFFFD, 32'd5, 32'd0, 32'd0, 64'hFFFFFFFF_FFFFFFF1, 2});
    // hold in DONE with start still asserted
    op = 3'd1; src_a = 32'hFFFFFFFF; src_b = 2; start = 1;
    sb.push_back(64'h00000001_FFFFFFFE);
    #1 chk("hd_stall0", stall, 1);
    @(posedge clk); #1;
    chk("hd_stall1", stall, 1);
    @(posedge clk); #1;
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      hold = (i < 2);
      #1;
      chk("hd_valid", {result_valid, stall}, 2'b10);
      chk("hd_result", {hi_out, lo_out}, e);
      @(posedge clk); #1;
    end
    start = 0;
    #1;
    chk("hd_idle", {busy, result_valid}, 0);
    // start and flush together in IDLE
    @(posedge clk); #1;
    op = 3'd0; start = 1; flush = 1;
    #1 chk("sf_stall", stall, 0);
    @(posedge clk); #1;
    start = 0; flush = 0;
    #1 chk("sf_idle", busy, 0);
    // reset mid-divide
    op = 3'd2; src_a = 50; src_b = 3; start = 1;
    repeat (5) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0; start = 0;
    #1 chk("rst_mid", {busy, result_valid, hi_out, lo_out}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Multi-cycle sequencer for the HI/LO arithmetic class (MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU) in the execute stage.
- Captures operands when the decoded op issues.
- Runs a registered multiplier or a 32-iteration radix-2 restoring divider.
- Stalls the pipeline until the 64-bit HI/LO result is ready, then presents it to the pipeline for the HI/LO write.
- Sits beside the ALU; its start/op come from the execute-stage decode of alucontrol.

Parameters:
- WIDTH, 32, operand width; HI/LO each WIDTH bits.
- MUL_LAT, 1, multiplier register stages spent in MUL state (1..3).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  execute-stage flush (exception/eret); cancels any operation.
- hold  in  1  stall from another source holding the execute stage.
- start  in  1  muldiv-class instruction present in the execute stage.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
- src_a  in  WIDTH  rs value (forwarded).
- src_b  in  WIDTH  rt value (forwarded).
- hi_in  in  WIDTH  current HI (forwarded); used by MADD/MSUB.
- lo_in  in  WIDTH  current LO (forwarded).
- stall  out  1  pipeline stall request (combinational).
- busy  out  1  state is not IDLE.
- result_valid  out  1  hi_out/lo_out valid.
- hi_out  out  WIDTH  HI result.
- lo_out  out  WIDTH  LO result.

Behaviour:
- Reset: state IDLE; result_valid=0; hi_out=lo_out=0; busy=0; stall=0; all internal registers cleared.
- States: IDLE, MUL, DIV, DONE.
- stall = ~flush & ((state==IDLE & start) | state==MUL | state==DIV).
  - Low in DONE, so the instruction advances with the result.
- IDLE → MUL/DIV, on start & ~flush.
  - Captures op, src_a, src_b, hi_in, lo_in.
  - DIV/DIVU with src_b==0 goes directly to DONE.
- MUL state:
  - Lasts MUL_LAT cycles.
  - Signed ops (0,4,6) use a 2WIDTH-bit signed product; unsigned ops use an unsigned product.
  - MADD/MADDU: {HI,LO} = {hi,lo} + product.
  - MSUB/MSUBU: {HI,LO} = {hi,lo} − product.
  - Both are mod 2^(2WIDTH), using the captured hi/lo.
  - Then → DONE.
- DIV state:
  - Operates on absolute values for DIV, raw values for DIVU.
  - One quotient bit per cycle, exactly 32 cycles, counter 0..31.
  - Last cycle applies sign correction and registers the result, then → DONE.
  - Quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
  - LO = quotient, HI = remainder.
- Divide by zero: LO=all ones, HI=src_a; no sign correction; result_valid one cycle after start.
- Latency from start cycle T:
  - MUL class: result_valid at T+1+MUL_LAT.
  - DIV: result_valid at T+33.
  - Stall is high every cycle before result_valid.
- DONE:
  - result_valid=1; hi_out/lo_out stable.
  - Stays in DONE while hold=1.
  - Returns to IDLE when hold=0.
  - start is ignored in DONE, so the same instruction never reissues.
- flush, any state: next state IDLE; result_valid=0 next cycle; stall=0 in the flush cycle itself.
  - A flush in the DONE cycle suppresses nothing already sampled; the pipeline discards the instruction.
- start & flush together in IDLE: no capture; remain IDLE.
- hold during MUL/DIV has no effect on progress; the operation continues.
- rst mid-operation: immediate return to reset values next edge.
- hi_out/lo_out retain their last result after DONE until the next completion.

Test Plan:
- MULT a=0xFFFFFFFD (−3), b=5, MUL_LAT=1 → stall high T,T+1; result_valid at T+2; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIVU a=100, b=7 → stall high T..T+32; result_valid at T+33; LO=14, HI=2. DIV a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MADD hi_in=0, lo_in=10, a=3, b=4 → {HI,LO}=0x0000_0000_0000_0016. MSUBU hi_in=0, lo_in=5, a=2, b=3 → {HI,LO}=0xFFFFFFFF_FFFFFFFF.
- DIV a=0x1234, b=0 → result_valid at T+1; LO=0xFFFFFFFF, HI=0x1234.
- DIVU 100/7 with flush at T+10 → stall=0 at T+10; IDLE at T+11; result_valid never asserts. A new MULT started at T+12 completes normally.
- MULTU 0xFFFFFFFF×2 with hold=1 during T+2..T+4 → result_valid T+2..T+4, no reissue; HI=1, LO=0xFFFFFFFE; IDLE at T+5.
